uart_rx: RTL and testbench

FSM-based UART receiver. It deserialises an asynchronous serial line into bytes, with optional even-parity checking and stop-bit checking. It sits directly upstream of the UART transmitter. Its rx_data/rx_valid outputs drive the transmitter's rx_data/rx_valid inputs, forming the loopback datapath. Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).

---
 rtl/uart_rx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// FSM-based UART receiver. Deserialises an asynchronous serial line into
// bytes: 1 start bit (0), 8 data bits LSB first, optional even-parity bit,
// 1 stop bit (1). Each bit is sampled at its midpoint. Back-to-back frames
// are supported because IDLE is re-entered at the middle of the stop bit.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           serial line, asynchronous to clk, idles high
//   parity_en    frame carries a parity bit; captured when the start bit
//                is validated and held for the rest of the frame
//   clk_per_bit  clk cycles per bit (4..8191), static during a frame
//   rx_data      last correctly received byte
//   rx_valid     one-cycle pulse: rx_data updated with a clean frame
//   parity_err   one-cycle pulse: parity mismatch
//   frame_err    one-cycle pulse: stop bit sampled low
//   busy         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        parity_en,
    input  logic [12:0] clk_per_bit,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchroniser chain plus one flop of history for falling-edge detection.
    // Both reset high so that reset release never looks like a start edge.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic                   sync;

    assign sync = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= sync;
        end
    end

    state_t      state_reg,   state_next;
    logic [12:0] cnt_reg,     cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg,   shift_next;
    logic        par_bad_reg, par_bad_next;
    logic        par_en_reg,  par_en_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        valid_reg,   valid_next;
    logic        perr_reg,    perr_next;
    logic        ferr_reg,    ferr_next;

    logic [12:0] half_m1;
    logic [12:0] bit_m1;

    // Start bit is checked half a bit in; every later bit one full bit on,
    // which keeps all samples centred.
    assign half_m1 = (clk_per_bit >> 1) - 13'd1;
    assign bit_m1  = clk_per_bit - 13'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
            par_en_reg  <= 1'b0;
            rx_data_reg <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            par_bad_reg <= par_bad_next;
            par_en_reg  <= par_en_next;
            rx_data_reg <= rx_data_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        par_bad_next = par_bad_reg;
        par_en_next  = par_en_reg;
        rx_data_next = rx_data_reg;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                par_bad_next = 1'b0;
                // Only a genuine high-to-low transition starts a frame, so a
                // line stuck low after a framing error is ignored.
                if (!sync && rx_prev_reg) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt_reg == half_m1) begin
                    cnt_next = '0;
                    if (!sync) begin
                        state_next  = DATA;
                        par_en_next = parity_en;
                    end else begin
                        // Glitch shorter than half a bit: drop silently.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 13'd1;
                end
            end

            DATA: begin
                if (cnt_reg == bit_m1) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = sync;
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 13'd1;
                end
            end

            PARITY: begin
                if (cnt_reg == bit_m1) begin
                    cnt_next     = '0;
                    par_bad_next = (sync != ^shift_reg);
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + 13'd1;
                end
            end

            STOP: begin
                if (cnt_reg == bit_m1) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (sync) begin
                        if (!par_bad_reg) begin
                            rx_data_next = shift_reg;
                            valid_next   = 1'b1;
                        end else begin
                            perr_next = 1'b1;
                        end
                    end else begin
                        ferr_next = 1'b1;
                        perr_next = par_bad_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + 13'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = valid_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The stimulus process drives frames bit by bit
// and queues the expected output pulse (flags, data, and the clock edge on
// which it must appear). A separate monitor pops and compares whenever any
// output pulse is present; a pulse with nothing queued is reported.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        parity_en;
    logic [12:0] clk_per_bit;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_en   (parity_en),
        .clk_per_bit (clk_per_bit),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: edge n is the posedge on which cyc becomes n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       v;
        logic       pe;
        logic       fe;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edge after which the result pulse of a frame starting at e0 is visible.
    function automatic int exp_cyc(input int e0, input int p);
        return e0 + 2 + CPB / 2 + 8 * CPB + p * CPB + CPB;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || parity_err || frame_err)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got v=%0b pe=%0b fe=%0b data=0x%0h, expected no pulse (cyc=%0d)",
                         rx_valid, parity_err, frame_err, rx_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_flags_data", int'({rx_valid, parity_err, frame_err, rx_data}),
                      int'({e.v, e.pe, e.fe, e.data}));
                check("pulse_cycle", cyc, e.cyc);
                $display("[TB] pulse v=%0b pe=%0b fe=%0b data=0x%02h at edge %0d (expected edge %0d)",
                         rx_valid, parity_err, frame_err, rx_data, cyc, e.cyc);
            end
        end
    end

    // Called 1 time unit after a posedge; returns at the same phase.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic pe, input logic fe,
                        input logic [7:0] d, input int c);
        exp_t e;
        e.v = v; e.pe = pe; e.fe = fe; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n       = 1'b0;
        rx          = 1'b1;
        parity_en   = 1'b0;
        clk_per_bit = 13'(CPB);
        #2;
        check("reset_rx_data",    rx_data,    0);
        check("reset_rx_valid",   rx_valid,   0);
        check("reset_parity_err", parity_err, 0);
        check("reset_frame_err",  frame_err,  0);
        check("reset_busy",       busy,       0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // 1: parity frame 0xA5, correct even parity 0
        parity_en = 1'b1;
        e0 = cyc + 1;
        push(1'b1, 1'b0, 1'b0, 8'hA5, exp_cyc(e0, 1));
        $display("[TB] send 0xA5 parity=0 e0=%0d", e0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(2 * CPB);

        // 2: back-to-back 0xA5, 0x3C without parity
        parity_en = 1'b0;
        e0 = cyc + 1;
        push(1'b1, 1'b0, 1'b0, 8'hA5, exp_cyc(e0, 0));
        push(1'b1, 1'b0, 1'b0, 8'h3C, exp_cyc(e0 + 10 * CPB, 0));
        $display("[TB] send 0xA5,0x3C back-to-back e0=%0d", e0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);

        // 3: 3-cycle low glitch
        $display("[TB] glitch 3 cycles");
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy_high", busy, 1);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_low", busy, 0);
        check("glitch_rx_data", rx_data, 8'h3C);
        idle(CPB);

        // 4: parity error, rx_data must hold 0x3C
        parity_en = 1'b1;
        e0 = cyc + 1;
        push(1'b0, 1'b1, 1'b0, 8'h3C, exp_cyc(e0, 1));
        $display("[TB] send 0xA5 parity=1 e0=%0d", e0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        idle(2 * CPB);

        // 5: frame error with line held low, then recovery with 0x81
        parity_en = 1'b0;
        e0 = cyc + 1;
        push(1'b0, 1'b0, 1'b1, 8'h3C, exp_cyc(e0, 0));
        $display("[TB] send 0x5A stop=0, hold low e0=%0d", e0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("ferr_hold_busy", busy, 0);
        idle(2 * CPB);
        e0 = cyc + 1;
        push(1'b1, 1'b0, 1'b0, 8'h81, exp_cyc(e0, 0));
        $display("[TB] send 0x81 e0=%0d", e0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);

        // 6: reset in the middle of data bit 4 of 0xFF
        $display("[TB] 0xFF aborted by reset in bit 4");
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("midframe_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_rx_data",    rx_data,    0);
        check("rst_rx_valid",   rx_valid,   0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_busy",       busy,       0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(CPB);
        e0 = cyc + 1;
        push(1'b1, 1'b0, 1'b0, 8'h0F, exp_cyc(e0, 0));
        $display("[TB] send 0x0F e0=%0d", e0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);

        check("final_rx_data", rx_data, 8'h0F);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
